// File: rtl/spi_master_byte.sv
// Byte-oriented SPI mode-0 master (CPOL=0, CPHA=0, MSB first) with a valid/ready
// byte stream in, one-cycle rx pulses out, and CS_n held across multi-byte frames.
module spi_master_byte #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       CS_n
);

    localparam int unsigned MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned MAX_C  = (MAX_AB > CS_HOLD) ? MAX_AB : CS_HOLD;
    localparam int unsigned CW     = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_DONE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    tx_q;
    logic [7:0]    rx_q;
    logic          last_q;
    logic          sck_q;
    logic          cs_n_q;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q;
    logic          accept;

    assign tx_ready = (state_q == S_IDLE) || (state_q == S_WAIT);
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state_q != S_IDLE);
    assign SCK      = sck_q;
    assign CS_n     = cs_n_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    // MOSI is the MSB of the tx shift register; filling with 1s keeps the idle level high.
    assign MOSI     = tx_q[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= '1;
            rx_q       <= '0;
            last_q     <= 1'b0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        tx_q    <= tx_data;
                        last_q  <= tx_last;
                        cs_n_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == CW'(CS_SETUP - 1)) begin
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_LOW;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_LOW: begin
                    if (cnt_q == CW'(CLK_DIV - 1)) begin
                        cnt_q   <= '0;
                        sck_q   <= 1'b1;
                        rx_q    <= {rx_q[6:0], MISO};
                        state_q <= S_HIGH;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_HIGH: begin
                    if (cnt_q == CW'(CLK_DIV - 1)) begin
                        cnt_q <= '0;
                        sck_q <= 1'b0;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_DONE;
                        end else begin
                            tx_q      <= {tx_q[6:0], 1'b1};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            state_q   <= S_LOW;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    rx_valid_q <= 1'b1;
                    rx_data_q  <= rx_q;
                    cnt_q      <= '0;
                    state_q    <= last_q ? S_HOLD : S_WAIT;
                end
                S_WAIT: begin
                    if (accept) begin
                        tx_q      <= tx_data;
                        last_q    <= tx_last;
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_LOW;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == CW'(CS_HOLD - 1)) begin
                        cnt_q   <= '0;
                        cs_n_q  <= 1'b1;
                        tx_q    <= '1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_byte.sv
// Scoreboard bench for spi_master_byte: loopback / tied MISO responders, frame timing
// relative to the accept edge, and reset abort.
module tb_spi_master_byte;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned CS_SETUP = 2;
    localparam int unsigned CS_HOLD  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h77;
    logic       tx_valid = 1'b1;
    logic       tx_last = 1'b1;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       SCK;
    logic       MOSI;
    logic       MISO;
    logic       CS_n;

    always #5 clk = ~clk;

    spi_master_byte #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_last (tx_last),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .SCK     (SCK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .CS_n    (CS_n)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Responder: 0 = MISO tied low, 1 = tied high, 2 = one-rise-delayed loopback
    logic [1:0] miso_mode = 2'd2;
    logic       lb_preset = 1'b0;
    logic       miso_lb   = 1'b1;
    logic       lb_prev   = 1'b1;

    always @(posedge SCK or posedge lb_preset) begin
        if (lb_preset) miso_lb <= 1'b1;
        else if (!CS_n) miso_lb <= MOSI;
    end

    assign MISO = (miso_mode == 2'd0) ? 1'b0 : (miso_mode == 2'd1) ? 1'b1 : miso_lb;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned rise_t[$];
    int unsigned fall_t[$];
    int unsigned csf_t[$];
    int unsigned csr_t[$];
    int unsigned rxv_t[$];
    logic        rise_mosi[$];
    logic [7:0]  exp_q[$];
    logic        sck_p = 1'b0;
    logic        cs_p  = 1'b1;

    always @(negedge clk) begin
        if (SCK === 1'b1 && sck_p === 1'b0) begin
            rise_t.push_back(cyc);
            rise_mosi.push_back(MOSI);
        end
        if (SCK === 1'b0 && sck_p === 1'b1) fall_t.push_back(cyc);
        if (CS_n === 1'b0 && cs_p === 1'b1) csf_t.push_back(cyc);
        if (CS_n === 1'b1 && cs_p === 1'b0) csr_t.push_back(cyc);
        if (rx_valid === 1'b1) begin
            rxv_t.push_back(cyc);
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        sck_p = SCK;
        cs_p  = CS_n;
    end

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int unsigned acc_t;

    function automatic logic [31:0] rel(input int unsigned t, input int unsigned a);
        return 32'(t - a + 1);
    endfunction

    task automatic clear_logs();
        rise_t.delete();
        fall_t.delete();
        csf_t.delete();
        csr_t.delete();
        rxv_t.delete();
        rise_mosi.delete();
    endtask

    task automatic preset_lb();
        miso_mode = 2'd2;
        lb_preset = 1'b1;
        #1;
        lb_preset = 1'b0;
        lb_prev   = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic last, input logic push, input logic [7:0] e);
        int unsigned w = 0;
        @(negedge clk);
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) begin
            check("send_timeout", 32'(tx_ready), 32'd1);
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_t    = cyc;
        tx_valid = 1'b0;
        if (push) exp_q.push_back(e);
    endtask

    task automatic send_lb(input logic [7:0] d, input logic last);
        logic [7:0] e;
        e       = {lb_prev, d[7:1]};
        lb_prev = d[0];
        send(d, last, 1'b1, e);
    endtask

    task automatic wait_idle();
        int unsigned w = 0;
        while (busy !== 1'b0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) check("idle_timeout", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int unsigned a1;
        int unsigned a2;
        logic [7:0]  v8;
        logic [15:0] v16;

        // Reset held with tx_valid high
        repeat (3) begin
            @(negedge clk);
            check("rst_cs_n", 32'(CS_n), 32'd1);
            check("rst_sck", 32'(SCK), 32'd0);
            check("rst_mosi", 32'(MOSI), 32'd1);
            check("rst_rx_valid", 32'(rx_valid), 32'd0);
            check("rst_rx_data", 32'(rx_data), 32'h00);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_tx_ready", 32'(tx_ready), 32'd1);
        end
        rst      = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_cs_n", 32'(CS_n), 32'd1);

        // Single byte, loopback
        clear_logs();
        preset_lb();
        send_lb(8'hA5, 1'b1);
        a1 = acc_t;
        wait_idle();
        v8 = 8'hA5;
        check("t1_rises", 32'(rise_t.size()), 32'd8);
        check("t1_falls", 32'(fall_t.size()), 32'd8);
        if (rise_t.size() == 8 && fall_t.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("t1_mosi", 32'(rise_mosi[i]), 32'(v8[7-i]));
                check("t1_high_w", 32'(fall_t[i] - rise_t[i]), 32'(CLK_DIV));
                if (i < 7) check("t1_low_w", 32'(rise_t[i+1] - fall_t[i]), 32'(CLK_DIV));
            end
            check("t1_first_rise", rel(rise_t[0], a1), 32'(1 + CS_SETUP + CLK_DIV));
            check("t1_last_fall", rel(fall_t[7], a1), 32'd67);
        end
        check("t1_cs_falls", 32'(csf_t.size()), 32'd1);
        check("t1_cs_rises", 32'(csr_t.size()), 32'd1);
        check("t1_rxv_count", 32'(rxv_t.size()), 32'd1);
        if (csf_t.size() == 1) check("t1_cs_low_at", rel(csf_t[0], a1), 32'd1);
        if (rxv_t.size() == 1) check("t1_rxv_at", rel(rxv_t[0], a1), 32'd68);
        if (csr_t.size() == 1) check("t1_cs_high_at", rel(csr_t[0], a1), 32'(68 + CS_HOLD));

        // Back-to-back two-byte frame
        clear_logs();
        preset_lb();
        send_lb(8'hA5, 1'b0);
        a1 = acc_t;
        send_lb(8'h3C, 1'b1);
        a2 = acc_t;
        wait_idle();
        v16 = 16'hA53C;
        check("t2_rises", 32'(rise_t.size()), 32'd16);
        check("t2_cs_falls", 32'(csf_t.size()), 32'd1);
        check("t2_cs_rises", 32'(csr_t.size()), 32'd1);
        check("t2_rxv_count", 32'(rxv_t.size()), 32'd2);
        if (rise_t.size() == 16) begin
            for (int i = 0; i < 16; i++) check("t2_mosi", 32'(rise_mosi[i]), 32'(v16[15-i]));
            check("t2_b1_first_rise", rel(rise_t[8], a2), 32'(1 + CLK_DIV));
        end
        if (rxv_t.size() == 2) begin
            check("t2_rxv0_at", rel(rxv_t[0], a1), 32'd68);
            check("t2_rxv1_at", rel(rxv_t[1], a2), 32'd66);
        end

        // Two-byte frame with the second byte withheld in WAIT
        clear_logs();
        preset_lb();
        send_lb(8'hA5, 1'b0);
        a1 = acc_t;
        begin
            int unsigned w = 0;
            while (rxv_t.size() == 0 && w < 200) begin
                @(negedge clk);
                #1;
                w++;
            end
            check("t3_first_rxv", 32'(rxv_t.size()), 32'd1);
        end
        repeat (20) begin
            @(negedge clk);
            check("t3_wait_sck", 32'(SCK), 32'd0);
            check("t3_wait_cs_n", 32'(CS_n), 32'd0);
            check("t3_wait_ready", 32'(tx_ready), 32'd1);
        end
        send_lb(8'h3C, 1'b1);
        a2 = acc_t;
        wait_idle();
        check("t3_rises", 32'(rise_t.size()), 32'd16);
        check("t3_cs_rises", 32'(csr_t.size()), 32'd1);
        check("t3_rxv_count", 32'(rxv_t.size()), 32'd2);
        if (rise_t.size() == 16) check("t3_b1_first_rise", rel(rise_t[8], a2), 32'(1 + CLK_DIV));
        if (rxv_t.size() == 2) check("t3_rxv1_at", rel(rxv_t[1], a2), 32'd66);

        // MISO tied low, then high
        clear_logs();
        miso_mode = 2'd0;
        send(8'h5A, 1'b1, 1'b1, 8'h00);
        wait_idle();
        check("t4_rises_lo", 32'(rise_t.size()), 32'd8);
        clear_logs();
        miso_mode = 2'd1;
        send(8'h5A, 1'b1, 1'b1, 8'hFF);
        wait_idle();
        check("t4_rises_hi", 32'(rise_t.size()), 32'd8);

        // Reset one cycle after the third SCK rise
        clear_logs();
        preset_lb();
        send(8'hC3, 1'b1, 1'b0, 8'h00);
        begin
            int unsigned r = 0;
            int unsigned w = 0;
            logic        sp;
            sp = SCK;
            while (r < 3 && w < 200) begin
                @(posedge clk);
                #1;
                if (SCK === 1'b1 && sp === 1'b0) r++;
                sp = SCK;
                w++;
            end
            check("t5_third_rise", 32'(r), 32'd3);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_cs_n", 32'(CS_n), 32'd1);
        check("t5_sck", 32'(SCK), 32'd0);
        check("t5_mosi", 32'(MOSI), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_rx_valid", 32'(rx_valid), 32'd0);
        repeat (100) @(negedge clk);
        check("t5_no_rxv", 32'(rxv_t.size()), 32'd0);
        clear_logs();
        preset_lb();
        send_lb(8'h81, 1'b1);
        wait_idle();
        check("t5_after_rises", 32'(rise_t.size()), 32'd8);
        check("t5_after_rxv", 32'(rxv_t.size()), 32'd1);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
